seg7_reader: RTL and testbench
==============================

Name: seg7_reader

Overview:
- Sequential inverse of the display's hex-to-segment path. It watches the time-multiplexed digit-enable and segment lines driven to a multi-digit 7-segment display and decodes each glyph back to its hex nibble.
- It assembles the digits into one word and presents it on a valid/ready interface.
- Used as a self-check and loopback monitor behind the display driver, and as a capture front-end on the bench.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; legal range 1..8.
- STABLE_CYCLES, 4: consecutive identical samples needed before a digit is accepted; must be >= 1.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_an  in  NUM_DIGITS  digit enables, active-low; bit k selects digit k (digit 0 = least-significant nibble).
- i_seg7  in  7  segments, active-low; bit6=g ... bit0=a.
- o_value  out  4*NUM_DIGITS  decoded frame; nibble k = digit k.
- o_err  out  1  frame contained at least one illegal glyph.
- o_valid  out  1  frame available.
- i_ready  in  1  consumer accepts the frame.

Behaviour:
- Glyph table (i_seg7 -> nibble), all other patterns illegal:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1011000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Sample register:
  - {i_an, i_seg7} is registered every cycle.
  - The stability counter increments (saturating at STABLE_CYCLES) when i_an has exactly one bit low and the current sample equals the previous one.
  - The counter loads 1 when i_an is one-hot-low but the sample differs from the previous one.
  - The counter clears to 0 when i_an is all ones or has more than one bit low.
- Capture:
  - Fires once per dwell, on the edge where the counter reaches STABLE_CYCLES.
  - Slot k is written with the decoded nibble and seen[k] is set.
  - An illegal glyph writes 4'h0 into slot k and sets the frame error accumulator.
  - Continued dwell on the same digit does not re-capture.
  - Re-capture of an already-seen digit before the frame completes overwrites slot k.
- FSM states:
  - COLLECT: seen != all ones. Moves to PENDING on the edge where seen becomes all ones.
  - PENDING: frame complete. Loads the output register on the next edge at which the output is free, i.e. o_valid==0 or (o_valid && i_ready). On load: o_value <= slots, o_err <= accumulator, o_valid <= 1, seen and accumulator cleared, then COLLECT.
  - While in PENDING, captures still overwrite slots, so the latest data wins.
- Latency: o_valid rises one edge after the capture edge of the last missing digit, when the output is free.
- Handshake:
  - Transfer occurs when o_valid && i_ready.
  - o_value and o_err hold stable while o_valid && !i_ready.
  - o_valid drops after a transfer unless a pending frame loads on the same edge.
- Reset (also mid-frame):
  - o_valid=0, o_value=0, o_err=0.
  - seen=0, accumulator=0, counter=0.
  - Previous sample = all ones; FSM = COLLECT.
  - A partially assembled frame is discarded.
- Counter width: $clog2(STABLE_CYCLES+1).

Optional Feature:
- Macro: SEG7_READER_DP_EN.
- When defined:
  - Adds input i_dp (1 bit, active-low decimal point) and output o_dp (NUM_DIGITS bits).
  - i_dp joins the stability compare.
  - o_dp[k] is the captured, active-high decimal point of digit k, loaded and reset together with o_value.
- When undefined: neither port exists and the decimal point is ignored.

Test Plan:
- Reset: assert i_rst 2 cycles -> o_valid=0, o_value=16'h0000, o_err=0.
- Basic frame (defaults), each step held 4 cycles, i_ready=1:
  - an=1110 seg=0100100, then an=1101 seg=1000110, then an=1011 seg=1011000, then an=0111 seg=0001110.
  - Expect o_valid for one cycle, one edge after the 4th sample of digit 3, with o_value=16'hF7C2 and o_err=0.
- Glitch rejection: digit 0 held 3 cycles then an=1111 -> no capture; seen unchanged; no o_valid.
- Illegal glyph: digit 1 seg=1111111, digits 0/2/3 showing "5","0","8" -> o_value=16'h8005, o_err=1.
- Backpressure:
  - i_ready=0; frame 16'h1234 presented; second frame 16'hABCD completes -> o_value holds 16'h1234.
  - Raise i_ready for one cycle -> next cycle o_valid=1 with o_value=16'hABCD.
- Reset mid-frame: capture digits 0 and 1, pulse i_rst, then capture digits 2 and 3 only -> no o_valid until digits 0 and 1 are captured again.

Source files
------------

// File: rtl/seg7_reader.sv
// seg7_reader: watches the multiplexed digit-enable / segment lines of a
// 7-segment display and decodes each glyph back into its hex nibble.
// Captured digits are assembled into a frame and handed out on valid/ready.
//
// Parameters:
//   NUM_DIGITS    (1..8) number of multiplexed digits
//   STABLE_CYCLES (>=1)  identical consecutive samples before a capture
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous reset, active-high
//   i_an     digit enables, active-low, bit k = digit k
//   i_seg7   segments, active-low, bit6=g .. bit0=a
//   o_value  decoded frame, nibble k = digit k
//   o_err    frame contained at least one illegal glyph
//   o_valid  frame available
//   i_ready  consumer accepts the frame
// Optional build macro SEG7_READER_DP_EN adds:
//   i_dp     decimal point, active-low, part of the stability compare
//   o_dp     captured decimal points, active-high, bit k = digit k

module seg7_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_DIGITS-1:0]   i_an,
  input  logic [6:0]              i_seg7,
`ifdef SEG7_READER_DP_EN
  input  logic                    i_dp,
  output logic [NUM_DIGITS-1:0]   o_dp,
`endif
  output logic [4*NUM_DIGITS-1:0] o_value,
  output logic                    o_err,
  output logic                    o_valid,
  input  logic                    i_ready
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

`ifdef SEG7_READER_DP_EN
  localparam int SW = NUM_DIGITS + 8;
`else
  localparam int SW = NUM_DIGITS + 7;
`endif

  typedef enum logic {
    COLLECT,
    PENDING
  } state_t;

  // Returns {legal, nibble}; illegal patterns decode as nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b0_0000;
    unique case (seg)
      7'b1000000: r = 5'h10;
      7'b1111001: r = 5'h11;
      7'b0100100: r = 5'h12;
      7'b0110000: r = 5'h13;
      7'b0011001: r = 5'h14;
      7'b0010010: r = 5'h15;
      7'b0000010: r = 5'h16;
      7'b1011000: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0010000: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b0000011: r = 5'h1B;
      7'b1000110: r = 5'h1C;
      7'b0100001: r = 5'h1D;
      7'b0000110: r = 5'h1E;
      7'b0001110: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  state_t                  state;
  logic [SW-1:0]           prev;
  logic [CW-1:0]           cnt;
  logic [NUM_DIGITS-1:0]   seen;
  logic                    acc;
  logic [4*NUM_DIGITS-1:0] slots;
`ifdef SEG7_READER_DP_EN
  logic [NUM_DIGITS-1:0]   slot_dp;
`endif

  logic [SW-1:0]         cur;
  logic [NUM_DIGITS-1:0] sel;
  logic                  one_hot;
  logic                  same;
  logic [4:0]            dec;
  logic                  legal;
  logic [3:0]            nib;
  logic                  cap;
  logic [NUM_DIGITS-1:0] cap_mask;
  logic [NUM_DIGITS-1:0] seen_nxt;
  logic [CW-1:0]         cnt_nxt;
  logic                  out_free;
  logic                  load;

  always_comb begin
`ifdef SEG7_READER_DP_EN
    cur = {i_dp, i_an, i_seg7};
`else
    cur = {i_an, i_seg7};
`endif
    sel     = ~i_an;
    one_hot = $onehot(sel);
    same    = (cur == prev);
    dec     = decode(i_seg7);
    legal   = dec[4];
    nib     = dec[3:0];

    cnt_nxt = '0;
    if (one_hot) begin
      if (!same)
        cnt_nxt = CNT_ONE;
      else if (cnt != CNT_MAX)
        cnt_nxt = cnt + CNT_ONE;
      else
        cnt_nxt = cnt;
    end

    // Fire once on the edge the counter reaches the threshold.
    // A fresh sample loads 1, which is the threshold only when it is 1.
    cap = 1'b0;
    if (one_hot) begin
      if (same)
        cap = (cnt == CNT_PRE);
      else
        cap = (STABLE_CYCLES == 1);
    end

    cap_mask = cap ? sel : '0;
    seen_nxt = seen | cap_mask;
    out_free = !o_valid || i_ready;
    load     = (state == PENDING) && out_free;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= COLLECT;
      prev    <= '1;
      cnt     <= '0;
      seen    <= '0;
      acc     <= 1'b0;
      slots   <= '0;
      o_value <= '0;
      o_err   <= 1'b0;
      o_valid <= 1'b0;
`ifdef SEG7_READER_DP_EN
      slot_dp <= '0;
      o_dp    <= '0;
`endif
    end else begin
      prev <= cur;
      cnt  <= cnt_nxt;

      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (cap_mask[k]) begin
          slots[4*k +: 4] <= nib;
`ifdef SEG7_READER_DP_EN
          slot_dp[k] <= ~i_dp;
`endif
        end
      end

      if (o_valid && i_ready)
        o_valid <= 1'b0;

      unique case (state)
        COLLECT: begin
          seen <= seen_nxt;
          if (cap && !legal)
            acc <= 1'b1;
          if (&seen_nxt)
            state <= PENDING;
        end
        PENDING: begin
          if (load) begin
            o_value <= slots;
            o_err   <= acc;
            o_valid <= 1'b1;
`ifdef SEG7_READER_DP_EN
            o_dp    <= slot_dp;
`endif
            // A capture landing on the load edge seeds the next frame.
            seen  <= cap_mask;
            acc   <= cap && !legal;
            state <= COLLECT;
          end else begin
            seen <= seen_nxt;
            if (cap && !legal)
              acc <= 1'b1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: directed test of seg7_reader with default parameters.
// Inputs change on the falling edge; outputs are checked #1 after rising.

module tb_seg7_reader;

  logic        clk;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        ready;
  logic [15:0] value;
  logic        err;
  logic        valid;
`ifdef SEG7_READER_DP_EN
  logic        dp;
  logic [3:0]  dp_out;
`endif

  int passed;
  int total;
  int vcount;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1011000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GB = 7'b0000011;
  localparam logic [6:0] GC = 7'b1000110;
  localparam logic [6:0] GD = 7'b0100001;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] GX = 7'b1111111;
  localparam logic [3:0] IDLE = 4'b1111;

  seg7_reader #(
    .NUM_DIGITS   (4),
    .STABLE_CYCLES(4)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_an   (an),
    .i_seg7 (seg),
`ifdef SEG7_READER_DP_EN
    .i_dp   (dp),
    .o_dp   (dp_out),
`endif
    .o_value(value),
    .o_err  (err),
    .o_valid(valid),
    .i_ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      an  = a;
      seg = s;
      @(posedge clk);
      #1;
      vcount += int'(valid);
    end
  endtask

  task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    hold(4'b1110, s0, 4);
    hold(4'b1101, s1, 4);
    hold(4'b1011, s2, 4);
    hold(4'b0111, s3, 4);
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    an    = IDLE;
    seg   = GX;
    ready = 1'b1;
    vcount = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid);
    else passed++;
    total++;
    if (value !== 16'h0000) $display("FAIL reset_value got %h want 0000", value);
    else passed++;
    total++;
    if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    vcount = 0;
    frame(G2, GC, G7, GF);
    total++;
    if (valid !== 1'b0 || vcount != 0)
      $display("FAIL basic_early got valid=%b cnt=%0d want 0/0", valid, vcount);
    else passed++;
    hold(IDLE, GX, 1);
    total++;
    if (valid !== 1'b1) $display("FAIL basic_valid got %b want 1", valid);
    else passed++;
    total++;
    if (value !== 16'hF7C2) $display("FAIL basic_value got %h want F7C2", value);
    else passed++;
    total++;
    if (err !== 1'b0) $display("FAIL basic_err got %b want 0", err);
    else passed++;
    hold(IDLE, GX, 1);
    total++;
    if (valid !== 1'b0 || vcount != 1)
      $display("FAIL basic_pulse got valid=%b cnt=%0d want 0/1", valid, vcount);
    else passed++;
  endtask

  task automatic test_glitch;
    vcount = 0;
    hold(4'b1110, G1, 3);
    hold(IDLE, GX, 1);
    hold(4'b1101, G3, 4);
    hold(4'b1011, G6, 4);
    hold(4'b0111, G8, 4);
    hold(IDLE, GX, 2);
    total++;
    if (vcount != 0) $display("FAIL glitch_novalid got %0d want 0", vcount);
    else passed++;
    hold(4'b1110, G1, 4);
    hold(IDLE, GX, 1);
    total++;
    if (valid !== 1'b1 || value !== 16'h8631)
      $display("FAIL glitch_frame got %b/%h want 1/8631", valid, value);
    else passed++;
    hold(IDLE, GX, 1);
  endtask

  task automatic test_illegal;
    vcount = 0;
    frame(G5, GX, G0, G8);
    hold(IDLE, GX, 1);
    total++;
    if (valid !== 1'b1 || value !== 16'h8005)
      $display("FAIL illegal_value got %b/%h want 1/8005", valid, value);
    else passed++;
    total++;
    if (err !== 1'b1) $display("FAIL illegal_err got %b want 1", err);
    else passed++;
    hold(IDLE, GX, 1);
  endtask

  task automatic test_backpressure;
    vcount = 0;
    ready = 1'b0;
    frame(G4, G3, G2, G1);
    hold(IDLE, GX, 1);
    total++;
    if (valid !== 1'b1 || value !== 16'h1234 || err !== 1'b0)
      $display("FAIL bp_first got %b/%h/%b want 1/1234/0", valid, value, err);
    else passed++;
    frame(GD, GC, GB, GA);
    hold(IDLE, GX, 2);
    total++;
    if (valid !== 1'b1 || value !== 16'h1234)
      $display("FAIL bp_hold got %b/%h want 1/1234", valid, value);
    else passed++;
    ready = 1'b1;
    hold(IDLE, GX, 1);
    ready = 1'b0;
    total++;
    if (valid !== 1'b1 || value !== 16'hABCD)
      $display("FAIL bp_second got %b/%h want 1/ABCD", valid, value);
    else passed++;
    hold(IDLE, GX, 1);
    total++;
    if (valid !== 1'b1 || value !== 16'hABCD)
      $display("FAIL bp_second_hold got %b/%h want 1/ABCD", valid, value);
    else passed++;
    ready = 1'b1;
    hold(IDLE, GX, 1);
    total++;
    if (valid !== 1'b0) $display("FAIL bp_drain got %b want 0", valid);
    else passed++;
  endtask

  task automatic test_reset_midframe;
    vcount = 0;
    hold(4'b1110, G1, 4);
    hold(4'b1101, G2, 4);
    @(negedge clk);
    rst = 1'b1;
    an  = IDLE;
    @(posedge clk);
    #1;
    total++;
    if (valid !== 1'b0 || value !== 16'h0000)
      $display("FAIL midrst_state got %b/%h want 0/0000", valid, value);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    hold(4'b1011, G7, 4);
    hold(4'b0111, GE, 4);
    hold(IDLE, GX, 2);
    total++;
    if (vcount != 0) $display("FAIL midrst_novalid got %0d want 0", vcount);
    else passed++;
    hold(4'b1110, G6, 4);
    hold(4'b1101, GF, 4);
    hold(IDLE, GX, 1);
    total++;
    if (valid !== 1'b1 || value !== 16'hE7F6)
      $display("FAIL midrst_frame got %b/%h want 1/E7F6", valid, value);
    else passed++;
    hold(IDLE, GX, 1);
  endtask

  initial begin
    passed = 0;
    total  = 0;
`ifdef SEG7_READER_DP_EN
    dp = 1'b1;
`endif
    test_reset;
    test_basic;
    test_glitch;
    test_illegal;
    test_backpressure;
    test_reset_midframe;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
